// File: rtl/irq_controller_mc_if.sv
// Bus and interrupt-presentation signals shared between the core side and the
// interrupt controller.
interface irq_controller_mc_if #(
    parameter int VEC_W = 4
);
    logic [3:0]       bus_addr;
    logic [31:0]      bus_wdata;
    logic             bus_we;
    logic             bus_re;
    logic [31:0]      bus_rdata;
    logic             irq_valid;
    logic [VEC_W-1:0] irq_vector;

    modport master (
        output bus_addr, bus_wdata, bus_we, bus_re,
        input  bus_rdata, irq_valid, irq_vector
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_we, bus_re,
        output bus_rdata, irq_valid, irq_vector
    );
endinterface

// File: rtl/irq_controller_mc.sv
// Multi-source interrupt controller: per-source pending/enable/mode state,
// fixed-priority dispatch of one vector at a time, completion from the CPU domain.
module irq_src_cell (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic src,
    input  logic wbit,
    input  logic en_we,
    input  logic mode_we,
    input  logic pend_w1c,
    input  logic ovf_clr,
    input  logic claim,
    output logic enable,
    output logic mode,
    output logic pending,
    output logic overflow
);
    logic src_q;
    logic rise;

    assign rise = src & ~src_q;

    // A new edge always wins over a same-cycle clear so no request is lost.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            src_q    <= 1'b0;
            enable   <= 1'b0;
            mode     <= 1'b1;
            pending  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            src_q <= src;
            if (en_we)   enable <= wbit;
            if (mode_we) mode   <= wbit;
            if (!mode)                          pending <= src;
            else if (rise)                      pending <= 1'b1;
            else if (claim || (pend_w1c && wbit)) pending <= 1'b0;
            if (mode && rise && pending) overflow <= 1'b1;
            else if (ovf_clr)            overflow <= 1'b0;
        end
    end
endmodule

module irq_controller_mc #(
    parameter int N_SRC = 8,
    parameter int VEC_W = 4
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [N_SRC-1:0] src_in,
    input  logic             irq_done_async,
    irq_controller_mc_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t           state;
    logic [N_SRC-1:0] enable, mode, pending, overflow, claim, req;
    logic [VEC_W-1:0] sel_idx;
    logic             wr_en, wr_mode, wr_pend, rd_stat;
    logic             done_s1, done_s2, done_s3, done_rise;
    logic [15:0]      ovf16;
    logic [31:0]      rd_mux;
    logic             unused_bits;

    assign unused_bits = ^{bus.bus_addr[1:0], bus.bus_wdata[31:N_SRC]};

    assign wr_en   = bus.bus_we && (bus.bus_addr[3:2] == 2'd0);
    assign wr_mode = bus.bus_we && (bus.bus_addr[3:2] == 2'd1);
    assign wr_pend = bus.bus_we && (bus.bus_addr[3:2] == 2'd2);
    assign rd_stat = bus.bus_re && (bus.bus_addr[3:2] == 2'd3);

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        irq_src_cell u_cell (
            .CLOCK_50 (CLOCK_50),
            .reset    (reset),
            .src      (src_in[g]),
            .wbit     (bus.bus_wdata[g]),
            .en_we    (wr_en),
            .mode_we  (wr_mode),
            .pend_w1c (wr_pend),
            .ovf_clr  (rd_stat),
            .claim    (claim[g]),
            .enable   (enable[g]),
            .mode     (mode[g]),
            .pending  (pending[g]),
            .overflow (overflow[g])
        );
    end

    assign req = pending & enable;

    // Lowest index has highest priority.
    always_comb begin
        sel_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (req[i]) sel_idx = VEC_W'(i);
        claim = '0;
        for (int i = 0; i < N_SRC; i++)
            claim[i] = (state == IDLE) && req[i] && (sel_idx == VEC_W'(i));
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            done_s1 <= 1'b0;
            done_s2 <= 1'b0;
            done_s3 <= 1'b0;
        end else begin
            done_s1 <= irq_done_async;
            done_s2 <= done_s1;
            done_s3 <= done_s2;
        end
    end

    assign done_rise = done_s2 & ~done_s3;

    // DRAIN holds off re-dispatch until the done level has fallen again.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            bus.irq_valid  <= 1'b0;
            bus.irq_vector <= '0;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    bus.irq_valid  <= 1'b1;
                    bus.irq_vector <= sel_idx + VEC_W'(1);
                    state          <= ACTIVE;
                end
                ACTIVE: if (done_rise) begin
                    bus.irq_valid  <= 1'b0;
                    bus.irq_vector <= '0;
                    state          <= DRAIN;
                end
                DRAIN: if (!done_s2) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ovf16 = '0;
        for (int i = 0; i < N_SRC && i < 16; i++) ovf16[i] = overflow[i];
    end

    always_comb begin
        rd_mux = '0;
        case (bus.bus_addr[3:2])
            2'd0:    rd_mux = 32'(enable);
            2'd1:    rd_mux = 32'(mode);
            2'd2:    rd_mux = 32'(pending);
            default: rd_mux = {ovf16, 16'(bus.irq_vector)};
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset)          bus.bus_rdata <= '0;
        else if (bus.bus_re) bus.bus_rdata <= rd_mux;
    end
endmodule

// File: tb/tb_irq_controller_mc.sv
// Randomised and directed bench for irq_controller_mc; a rule-level model feeds
// scoreboard queues that a separate monitor drains as the DUT responds.
module tb_irq_controller_mc;
    localparam int N  = 8;
    localparam int VW = 4;

    logic         CLOCK_50 = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] src_in = '0;
    logic         irq_done_async = 1'b0;

    irq_controller_mc_if #(.VEC_W(VW)) bif();

    irq_controller_mc #(.N_SRC(N), .VEC_W(VW)) dut (
        .CLOCK_50       (CLOCK_50),
        .reset          (reset),
        .src_in         (src_in),
        .irq_done_async (irq_done_async),
        .bus            (bif)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct { int cyc; int vec; } ev_t;
    ev_t         evq[$];
    logic [31:0] rdq[$];
    int          n_tests = 0;
    int          n_fail = 0;

    // Reference model: bit vectors per register, dispatch state as 0 idle / 1 presenting / 2 waiting for done low.
    logic [N-1:0] m_en, m_mode, m_pend, m_ovf, m_srcq;
    logic         m_d1, m_d2, m_d3;
    int           m_st, m_vec, cyc;
    bit           rd_due;

    task automatic m_reset();
        m_en = '0; m_mode = '1; m_pend = '0; m_ovf = '0; m_srcq = '0;
        m_d1 = 0; m_d2 = 0; m_d3 = 0;
        m_st = 0; m_vec = 0; rd_due = 0;
        evq.delete(); rdq.delete();
    endtask

    function automatic logic [31:0] m_rd(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_en);
            2'd1:    return 32'(m_mode);
            2'd2:    return 32'(m_pend);
            default: return (32'(m_ovf) << 16) | 32'(m_vec);
        endcase
    endfunction

    task automatic m_step();
        logic [N-1:0] rise, req, claim, npend, novf;
        logic [1:0]   a;
        int           sel;
        cyc++;
        a     = bif.bus_addr[3:2];
        rise  = src_in & ~m_srcq;
        req   = m_pend & m_en;
        claim = '0;
        if (bif.bus_re) rdq.push_back(m_rd(a));
        rd_due = bif.bus_re;
        if (m_st == 0) begin
            if (req != 0) begin
                sel = 0;
                while (!req[sel]) sel++;
                claim[sel] = m_mode[sel];
                m_vec = sel + 1;
                m_st = 1;
                evq.push_back('{cyc, m_vec});
            end
        end else if (m_st == 1) begin
            if (m_d2 && !m_d3) begin
                m_vec = 0;
                m_st = 2;
                evq.push_back('{cyc, 0});
            end
        end else if (!m_d2) m_st = 0;
        npend = m_pend;
        novf  = m_ovf;
        if (bif.bus_re && a == 2'd3) novf = '0;
        for (int i = 0; i < N; i++) begin
            if (!m_mode[i]) npend[i] = src_in[i];
            else if (rise[i]) begin
                npend[i] = 1'b1;
                if (m_pend[i]) novf[i] = 1'b1;
            end else if (claim[i] || (bif.bus_we && a == 2'd2 && bif.bus_wdata[i])) npend[i] = 1'b0;
        end
        m_pend = npend;
        m_ovf  = novf;
        if (bif.bus_we && a == 2'd0) m_en   = bif.bus_wdata[N-1:0];
        if (bif.bus_we && a == 2'd1) m_mode = bif.bus_wdata[N-1:0];
        m_srcq = src_in;
        m_d3 = m_d2; m_d2 = m_d1; m_d1 = irq_done_async;
    endtask

    always @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) m_reset();
        else        m_step();
    end

    // Monitor: compares each DUT output change and each read response against the queues.
    logic          pv;
    logic [VW-1:0] pvec;
    always @(negedge CLOCK_50) begin
        ev_t         e;
        logic [31:0] exp;
        if (!reset) begin
            pv = 1'b0; pvec = '0;
        end else begin
            if (rd_due) begin
                n_tests++;
                if (rdq.size() == 0) begin
                    n_fail++;
                    $display("FAIL rdata: got %h with no read queued", bif.bus_rdata);
                end else begin
                    exp = rdq.pop_front();
                    if (bif.bus_rdata !== exp) begin
                        n_fail++;
                        $display("FAIL rdata @%0d: got %h required %h", cyc, bif.bus_rdata, exp);
                    end
                end
            end
            while (evq.size() > 0 && evq[0].cyc < cyc) begin
                e = evq.pop_front();
                n_tests++; n_fail++;
                $display("FAIL irq_missing: vector %0d due at cycle %0d, still valid=%0b vec=%0d at %0d",
                         e.vec, e.cyc, bif.irq_valid, bif.irq_vector, cyc);
            end
            if (bif.irq_valid !== pv || bif.irq_vector !== pvec) begin
                n_tests++;
                if (evq.size() == 0) begin
                    n_fail++;
                    $display("FAIL irq_change @%0d: got valid=%0b vec=%0d, required no change",
                             cyc, bif.irq_valid, bif.irq_vector);
                end else begin
                    e = evq.pop_front();
                    if (bif.irq_valid !== (e.vec != 0) || bif.irq_vector !== VW'(e.vec) || e.cyc != cyc) begin
                        n_fail++;
                        $display("FAIL irq_change @%0d: got valid=%0b vec=%0d, required vec=%0d at %0d",
                                 cyc, bif.irq_valid, bif.irq_vector, e.vec, e.cyc);
                    end
                end
                pv = bif.irq_valid; pvec = bif.irq_vector;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bif.bus_addr = {a, 2'b00}; bif.bus_wdata = d; bif.bus_we = 1'b1;
        @(negedge CLOCK_50);
        bif.bus_we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a);
        bif.bus_addr = {a, 2'b00}; bif.bus_re = 1'b1;
        @(negedge CLOCK_50);
        bif.bus_re = 1'b0;
    endtask

    task automatic pulse(input logic [N-1:0] m);
        src_in = m;
        @(negedge CLOCK_50);
        src_in = '0;
    endtask

    task automatic complete();
        irq_done_async = 1'b1; cycles(5);
        irq_done_async = 1'b0; cycles(5);
    endtask

    initial begin
        bif.bus_addr = '0; bif.bus_wdata = '0; bif.bus_we = 1'b0; bif.bus_re = 1'b0;
        m_reset();
        cyc = 0;
        #5;
        chk("reset_valid", 32'(bif.irq_valid), 32'd0);
        chk("reset_vector", 32'(bif.irq_vector), 32'd0);
        chk("reset_rdata", bif.bus_rdata, 32'd0);
        cycles(3);
        reset = 1'b1;
        cycles(1);
        rd(0); rd(1); rd(2); rd(3);

        // single edge source
        wr(0, 32'h01);
        src_in = 8'h01; @(negedge CLOCK_50); src_in = '0; @(negedge CLOCK_50);
        chk("single_vec", 32'(bif.irq_vector), 32'd1);
        rd(2);
        irq_done_async = 1'b1; cycles(4);
        chk("single_done", 32'(bif.irq_valid), 32'd0);
        rd(3);
        irq_done_async = 1'b0; cycles(4);

        // priority: vector 3 then 6
        wr(0, 32'hFF);
        pulse(8'h24); cycles(2);
        complete();
        complete();
        rd(2);

        // overflow with masking
        wr(0, 32'h00);
        pulse(8'h02); cycles(1); pulse(8'h02); cycles(1);
        rd(2); rd(3); rd(3);
        wr(2, 32'h02); rd(2);

        // level mode with re-dispatch
        wr(1, 32'hFE); wr(0, 32'h02);
        src_in = 8'h02; cycles(4);
        complete();
        src_in = '0; cycles(1);
        complete();
        rd(2);
        wr(1, 32'hFF);

        // held done across a new request
        wr(0, 32'h01);
        pulse(8'h01); cycles(2);
        irq_done_async = 1'b1; cycles(5);
        pulse(8'h01); cycles(8);
        irq_done_async = 1'b0; cycles(6);
        complete();

        // randomised traffic
        for (int c = 0; c < 3000; c++) begin
            int r;
            src_in = N'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 7) == 0) irq_done_async = ~irq_done_async;
            r = $urandom_range(0, 9);
            bif.bus_addr  = 4'($urandom_range(0, 15));
            bif.bus_wdata = $urandom;
            bif.bus_we    = (r == 0);
            bif.bus_re    = (r == 1 || r == 2);
            @(negedge CLOCK_50);
            bif.bus_we = 1'b0; bif.bus_re = 1'b0;
        end
        src_in = '0; irq_done_async = 1'b0; cycles(4);

        // reset while presenting vector 4
        reset = 1'b0; cycles(2); reset = 1'b1; cycles(1);
        wr(0, 32'h08);
        pulse(8'h08); cycles(2);
        chk("pre_reset_vec", 32'(bif.irq_vector), 32'd4);
        #3 reset = 1'b0;
        #1;
        chk("async_reset_valid", 32'(bif.irq_valid), 32'd0);
        chk("async_reset_vector", 32'(bif.irq_vector), 32'd0);
        chk("async_reset_rdata", bif.bus_rdata, 32'd0);
        cycles(2);
        reset = 1'b1; cycles(1);
        rd(0); rd(1);
        cycles(4);

        chk("evq_drained", 32'(evq.size()), 32'd0);
        chk("rdq_drained", 32'(rdq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
